// File: rtl/bitscan_pkg.sv
// bitscan_pkg: shared definitions for the bit-scan unit.
//   mode_e       - operation select encoding (CLZ, CTZ, POP, CLS)
//   count_width  - width of the internal count datapath for a given operand width
package bitscan_pkg;

  typedef enum logic [1:0] {
    MODE_CLZ = 2'b00,
    MODE_CTZ = 2'b01,
    MODE_POP = 2'b10,
    MODE_CLS = 2'b11
  } mode_e;

  // A WIDTH-bit operand can yield a count of exactly WIDTH, hence the extra bit.
  function automatic int count_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/bitscan_if.sv
// bitscan_if: operand/result handshake bundle for the bit-scan unit.
//   in_valid/in_ready/in_data/in_mode     - operand channel (producer -> unit)
//   out_valid/out_ready/out_count/out_zero - result channel (unit -> consumer)
//   modport master: the side that issues operands and consumes results
//   modport slave : the bit-scan unit itself
interface bitscan_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_count;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_count, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_count, out_zero
  );

endinterface

// File: rtl/bitscan_unit_nibble_scan.sv
// nibble_scan: purely combinational summary of one 4-bit slice.
//   nibble   in  4  slice of the preprocessed operand
//   all_zero out 1  slice is 0000
//   lz       out 2  leading zeros inside the slice (meaningless when all_zero)
//   pop      out 3  number of set bits, 0..4
module nibble_scan (
  input  logic [3:0] nibble,
  output logic       all_zero,
  output logic [1:0] lz,
  output logic [2:0] pop
);

  // Zero flag, in-slice leading-zero code and slice popcount.
  always_comb begin
    all_zero = (nibble == 4'b0000);
    casez (nibble)
      4'b1???: lz = 2'd0;
      4'b01??: lz = 2'd1;
      4'b001?: lz = 2'd2;
      default: lz = 2'd3;
    endcase
    pop = {2'b00, nibble[0]} + {2'b00, nibble[1]} +
          {2'b00, nibble[2]} + {2'b00, nibble[3]};
  end

endmodule

// File: rtl/bitscan_unit.sv
// bitscan_unit: two-stage valid/ready bit-scan (CLZ / CTZ / POP / CLS).
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-high reset; flushes both stages
//   bus    slave side of bitscan_if: operand in, zero-extended count out
// S1 registers per-nibble summaries of the preprocessed operand; S2 combines
// them and registers the final count. out_ready reaches in_ready combinationally.
module bitscan_unit
  import bitscan_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  bitscan_if.slave bus
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = count_width(WIDTH);

  mode_e                in_mode_s;
  logic [WIDTH-1:0]     rev_s;
  logic [WIDTH-1:0]     pre_s;
  logic [NIB-1:0]       nib_az_s;
  logic [NIB-1:0][1:0]  nib_lz_s;
  logic [NIB-1:0][2:0]  nib_pop_s;

  logic                 s1_valid_r;
  mode_e                s1_mode_r;
  logic                 s1_zero_r;
  logic [NIB-1:0]       s1_az_r;
  logic [NIB-1:0][1:0]  s1_lz_r;
  logic [NIB-1:0][2:0]  s1_pop_r;

  logic                 s2_valid_r;
  logic [WIDTH-1:0]     out_count_r;
  logic                 out_zero_r;

  logic                 s2_adv_s;
  logic                 in_ready_s;
  logic                 in_fire_s;
  logic [CW-1:0]        lead_s;
  logic [CW-1:0]        pop_sum_s;
  logic [CW-1:0]        result_s;

  assign in_mode_s = mode_e'(bus.in_mode);

  // Bit-reversed operand: CTZ becomes a leading-zero count on it.
  always_comb begin
    rev_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      rev_s[i] = bus.in_data[WIDTH-1-i];
    end
  end

  // Mode-dependent preprocessing. For CLS, XOR with the replicated MSB turns
  // sign-copies into leading zeros; the forced-zero MSB is removed in S2.
  always_comb begin
    case (in_mode_s)
      MODE_CTZ: pre_s = rev_s;
      MODE_CLS: pre_s = bus.in_data ^ {WIDTH{bus.in_data[WIDTH-1]}};
      default:  pre_s = bus.in_data;
    endcase
  end

  for (genvar g = 0; g < NIB; g++) begin : g_nib
    nibble_scan u_nibble_scan (
      .nibble   (pre_s[4*g +: 4]),
      .all_zero (nib_az_s[g]),
      .lz       (nib_lz_s[g]),
      .pop      (nib_pop_s[g])
    );
  end

  // S2 may take a new item when it is empty or its result is being taken.
  assign s2_adv_s   = !s2_valid_r || bus.out_ready;
  assign in_ready_s = !reset && (!s1_valid_r || s2_adv_s);
  assign in_fire_s  = bus.in_valid && in_ready_s;

  // S1 register: nibble summaries plus mode and operand-zero flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_mode_r  <= MODE_CLZ;
      s1_zero_r  <= 1'b0;
      s1_az_r    <= '0;
      s1_lz_r    <= '0;
      s1_pop_r   <= '0;
    end else begin
      if (!s1_valid_r || s2_adv_s) begin
        s1_valid_r <= in_fire_s;
      end
      if (in_fire_s) begin
        s1_mode_r <= in_mode_s;
        s1_zero_r <= (bus.in_data == {WIDTH{1'b0}});
        s1_az_r   <= nib_az_s;
        s1_lz_r   <= nib_lz_s;
        s1_pop_r  <= nib_pop_s;
      end
    end
  end

  // Priority combine: ascending scan so the highest non-zero nibble wins.
  // {nibble distance from the top, in-nibble code} forms the leading count.
  always_comb begin
    lead_s = CW'(WIDTH);
    for (int i = 0; i < NIB; i++) begin
      if (!s1_az_r[i]) begin
        lead_s = CW'((NIB - 1 - i) * 4) + CW'(s1_lz_r[i]);
      end else begin
        lead_s = lead_s;
      end
    end
  end

  // Popcount adder over the nibble counts.
  always_comb begin
    pop_sum_s = {CW{1'b0}};
    for (int i = 0; i < NIB; i++) begin
      pop_sum_s = pop_sum_s + CW'(s1_pop_r[i]);
    end
  end

  // Result select. CLS operand MSB is always 0 after XOR, so lead_s >= 1.
  always_comb begin
    case (s1_mode_r)
      MODE_CLZ: result_s = lead_s;
      MODE_CTZ: result_s = lead_s;
      MODE_POP: result_s = pop_sum_s;
      MODE_CLS: result_s = lead_s - CW'(1'b1);
      default:  result_s = lead_s;
    endcase
  end

  // S2 register: holds the presented result steady until it is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_r  <= 1'b0;
      out_count_r <= {WIDTH{1'b0}};
      out_zero_r  <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_count_r <= WIDTH'(result_s);
        out_zero_r  <= s1_zero_r;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s2_valid_r;
  assign bus.out_count = out_count_r;
  assign bus.out_zero  = out_zero_r;

endmodule
